// File: rtl/datapath_defs_pkg.sv
// rtl/datapath_defs_pkg.sv - opcode constants and default widths shared with the control unit
package datapath_defs;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_BITS_DEF  = 5;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_ROL   = 4'h8,
    OP_ROR   = 4'h9,
    OP_INC   = 4'hA,
    OP_DEC   = 4'hB,
    OP_SLTU  = 4'hC,
    OP_PASSA = 4'hD,
    OP_PASSB = 4'hE,
    OP_NOP   = 4'hF
  } opcode_e;

endpackage

// File: rtl/datapath_unit_alu.sv
// rtl/datapath_unit_alu.sv - combinational ALU with carry/borrow output
module alu
  import datapath_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry
);

  logic [DATA_WIDTH:0]     wide;
  logic [2*DATA_WIDTH-1:0] rot;
  logic [2:0]              shamt;

  assign shamt = b[2:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    wide   = '0;
    rot    = '0;
    case (opcode_e'(op))
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (b > a)
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_SHL:   result = a << shamt;
      OP_SHR:   result = a >> shamt;
      OP_ROL: begin
        rot    = {a, a} << shamt;
        result = rot[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      OP_ROR: begin
        rot    = {a, a} >> shamt;
        result = rot[DATA_WIDTH-1:0];
      end
      OP_INC: begin
        wide   = {1'b0, a} + (DATA_WIDTH+1)'(1);
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      OP_DEC: begin
        wide   = {1'b0, a} - (DATA_WIDTH+1)'(1);
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      OP_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      OP_PASSA: result = a;
      OP_PASSB: result = b;
      OP_NOP:   result = '0;
    endcase
  end

endmodule

// File: rtl/datapath_unit.sv
// rtl/datapath_unit.sv - registered ALU stage, read-first data memory and write-back mux
module datapath_unit
  import datapath_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] alu_b, alu_res;
  logic                  alu_carry;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mem_q, mem_d;
  logic                  wr_q, wr_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic [ADDR_BITS-1:0]  addr;
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  assign alu_b = sel3 ? offset : operand2;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (operand1),
    .b      (alu_b),
    .op     (opcode),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // Upper bits of the ALU result are ignored, so addresses wrap
  assign addr = alu_q[ADDR_BITS-1:0];

  always_comb begin
    alu_d   = alu_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (opcode != OP_NOP) begin
      alu_d   = alu_res;
      wr_d    = w_r;
      wdata_d = operand2;
      zero_d  = (alu_res == '0);
      carry_d = alu_carry;
    end
    mem_d = ram_q[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      mem_q   <= '0;
    end else begin
      alu_q   <= alu_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      mem_q   <= mem_d;
    end
  end

  // Read-first: mem_d samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else if (wr_q) begin
      ram_q[addr] <= wdata_q;
    end
  end

  assign result2 = sel1 ? alu_q : mem_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_datapath_unit.sv
// tb/tb_datapath_unit.sv - directed self-checking bench for datapath_unit
module tb_datapath_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] operand1, operand2, offset;
  logic [3:0] opcode;
  logic       sel1, sel3, w_r;
  logic [7:0] result2;
  logic       zero, carry;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_unit dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .offset   (offset),
    .opcode   (opcode),
    .sel1     (sel1),
    .sel3     (sel3),
    .w_r      (w_r),
    .result2  (result2),
    .zero     (zero),
    .carry    (carry)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b2, input logic [7:0] off,
                       input logic [3:0] op, input logic s3, input logic wr);
    operand1 = a;
    operand2 = b2;
    offset   = off;
    opcode   = op;
    sel3     = s3;
    w_r      = wr;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] exp;
    logic       c;
  } vec_t;

  vec_t vecs[10] = '{
    '{8'h81, 8'h01, 4'h8, 8'h03, 1'b0},
    '{8'h81, 8'h01, 4'h9, 8'hC0, 1'b0},
    '{8'h96, 8'h03, 4'h6, 8'hB0, 1'b0},
    '{8'h96, 8'h03, 4'h7, 8'h12, 1'b0},
    '{8'h00, 8'h00, 4'hB, 8'hFF, 1'b1},
    '{8'hFF, 8'h00, 4'hA, 8'h00, 1'b1},
    '{8'h03, 8'h05, 4'hC, 8'h01, 1'b0},
    '{8'hF0, 8'h3C, 4'h4, 8'hCC, 1'b0},
    '{8'h55, 8'h00, 4'h5, 8'hAA, 1'b0},
    '{8'h12, 8'h34, 4'hE, 8'h34, 1'b0}
  };

  initial begin
    rst = 1'b1;
    sel1 = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    check_eq("reset_result_alu", result2, 0);
    sel1 = 1'b0; #1;
    check_eq("reset_result_mem", result2, 0);
    check_eq("reset_zero", zero, 0);
    check_eq("reset_carry", carry, 0);

    sel1 = 1'b1;
    tick();
    check_eq("first_add_result", result2, 0);
    check_eq("first_add_zero", zero, 1);

    sel1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(8'(i), 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
      tick();
      tick();
      check_eq($sformatf("mem_init_%0d", i), result2, 0);
    end

    sel1 = 1'b1;
    drive(8'h02, 8'h03, 8'h00, 4'h0, 1'b0, 1'b0);
    tick();
    check_eq("add_2_3", result2, 8'h05);
    check_eq("add_2_3_carry", carry, 0);
    check_eq("add_2_3_zero", zero, 0);
    drive(8'hFF, 8'h01, 8'h00, 4'h0, 1'b0, 1'b0);
    tick();
    check_eq("add_ff_1", result2, 8'h00);
    check_eq("add_ff_1_zero", zero, 1);
    check_eq("add_ff_1_carry", carry, 1);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].a, vecs[i].b, 8'h00, vecs[i].op, 1'b0, 1'b0);
      tick();
      check_eq($sformatf("alu_vec_%0d", i), result2, vecs[i].exp);
      check_eq($sformatf("alu_vec_%0d_carry", i), carry, vecs[i].c);
    end

    // Store 0xA5 at 1+4, held for three cycles, then load it back
    drive(8'h01, 8'hA5, 8'h04, 4'h0, 1'b1, 1'b1);
    tick(); tick(); tick();
    drive(8'h01, 8'h00, 8'h04, 4'h0, 1'b1, 1'b0);
    sel1 = 1'b0;
    tick(); tick();
    check_eq("load_a5", result2, 8'hA5);

    // 0x20 + 0x05 = 0x25 wraps to address 5
    drive(8'h20, 8'h3C, 8'h05, 4'h0, 1'b1, 1'b1);
    tick();
    drive(8'h20, 8'h3C, 8'h05, 4'h0, 1'b1, 1'b0);
    tick();
    drive(8'h05, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0);
    tick(); tick();
    check_eq("wrap_load_5", result2, 8'h3C);

    // Same-edge read/write at address 7
    drive(8'h07, 8'h11, 8'h00, 4'h0, 1'b1, 1'b1);
    tick();
    drive(8'h07, 8'h11, 8'h00, 4'h0, 1'b1, 1'b0);
    tick();
    drive(8'h07, 8'h22, 8'h00, 4'h0, 1'b1, 1'b1);
    tick();
    drive(8'h07, 8'h22, 8'h00, 4'h0, 1'b1, 1'b0);
    tick();
    check_eq("read_first_old", result2, 8'h11);
    tick();
    check_eq("read_after_write", result2, 8'h22);

    // Reset right after stage 1 of a store drops the write
    drive(8'h09, 8'h77, 8'h00, 4'h0, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    w_r = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("rst_mid_result", result2, 0);
    drive(8'h09, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0);
    tick(); tick();
    check_eq("rst_dropped_write", result2, 0);

    // NOP holds alu_q, zero, carry after SUB 3-5
    sel1 = 1'b1;
    drive(8'h03, 8'h05, 8'h00, 4'h1, 1'b0, 1'b0);
    tick();
    check_eq("sub_3_5", result2, 8'hFE);
    check_eq("sub_3_5_carry", carry, 1);
    drive(8'h00, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0);
    tick(); tick();
    check_eq("nop_hold_result", result2, 8'hFE);
    check_eq("nop_hold_carry", carry, 1);
    check_eq("nop_hold_zero", zero, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
